mips_load_store_unit: RTL and testbench
=======================================

Name: mips_load_store_unit

Overview:
Initiator side of the data-memory interface for the single-cycle MIPS datapath.
- Accepts one load/store request at a time from the core; a request carries the MIPS opcode, effective address and store data.
- Drives word-addressed read/write strobes to the data memory.
- Performs byte/halfword lane selection with sign/zero extension on loads, and read-modify-write for sub-word stores.
- Returns a one-cycle response carrying the load data or a fault flag.

Parameters:
- BASE_ADDR, 32'h10001000, byte address of data-memory word 0.
- DEPTH_WORDS, 16, number of 32-bit words in the data-memory window.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_opcode  in  6  MIPS opcode: LB 100000, LH 100001, LW 100011, LBU 100100, LHU 100101, SB 101000, SH 101001, SW 101011.
- req_addr  in  32  effective byte address.
- req_wdata  in  32  store data; byte/halfword taken from the low bits.
- resp_valid  out  1  one-cycle response strobe.
- resp_rdata  out  32  extended load result; 0 for stores and faults.
- resp_fault  out  1  response is a fault (misaligned, illegal opcode, out of range).
- mem_address  out  32  byte address to the data memory; always word-aligned.
- mem_write_data  out  32  write word.
- mem_read  out  1  read strobe.
- mem_write  out  1  write strobe.
- mem_read_data  in  32  read word; combinational from the memory and valid while mem_read is high.

Behaviour:
- Reset (async): state IDLE; req_ready=1; resp_valid=0; resp_fault=0; resp_rdata=0; mem_read=0; mem_write=0; mem_address=0; mem_write_data=0.
- Handshake: a request is accepted on the edge where req_valid & req_ready. Opcode, address and data are captured into internal registers at acceptance. Inputs are ignored outside IDLE.
- States: IDLE, RD, RMW_RD, WR, RESP.
  - IDLE -> RESP on accept with fault (no memory strobe).
  - IDLE -> RD for a load.
  - IDLE -> WR for SW.
  - IDLE -> RMW_RD for SB/SH.
  - RD -> RESP.
  - RMW_RD -> WR.
  - WR -> RESP.
  - RESP -> IDLE.
- Strobes are registered outputs, asserted for exactly one cycle while in RD, RMW_RD and WR. mem_address = {addr[31:2], 2'b00} throughout an access.
- mem_read_data is sampled on the edge leaving RD or RMW_RD.
- Latency, acceptance edge to resp_valid high:
  - load and SW: 2 cycles;
  - SB/SH: 3 cycles;
  - fault: 1 cycle.
- resp_valid is high for exactly one cycle (the RESP state). There is no response backpressure. req_ready returns high in the cycle after RESP.
- Byte lanes are big-endian.
  - Byte offset 0 -> bits [31:24], offset 3 -> bits [7:0].
  - Halfword offset 0 -> bits [31:16], offset 2 -> bits [15:0].
- Loads: LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Sub-word store: merge req_wdata[7:0] or [15:0] into the read word at the addressed lane, other lanes unchanged; the merged word is written in WR.
- Faults:
  - LH/LHU/SH with addr[0]=1 are misaligned.
  - LW/SW with addr[1:0]!=0 are misaligned.
  - Any unlisted opcode is illegal.
  - A faulting request never asserts mem_read or mem_write; resp_rdata=0.
- Reset asserted mid-operation aborts immediately: strobes drop asynchronously, no response is produced, and the partial RMW write is lost.
- Fault priority: illegal opcode is checked first, then misalignment, then range. The single resp_fault bit covers all three.

Optional Feature:
Macro LSU_RANGE_CHECK_EN.
- Defined: an address outside [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS - 1] faults at acceptance with no memory access. Default window is 0x10001000..0x1000103F.
- Undefined: no range check; any aligned address is issued to memory unchanged.

Test Plan:
- Memory model with word 4 (0x10001010) = 0x12345678: LW 0x10001010 -> mem_read high for 1 cycle with mem_address 0x10001010; resp_valid 2 cycles after accept; resp_rdata 0x12345678; resp_fault 0.
- Byte loads on that word: LB 0x10001010 -> 0x00000012; LB 0x10001013 -> 0x00000078; LH 0x10001012 -> 0x00005678. Set the word to 0x80FF0000: LB 0x10001010 -> 0xFFFFFF80; LBU -> 0x00000080; LHU 0x10001010 -> 0x000080FF.
- SB 0x10001011 with wdata 0x000000AB on word 0x12345678 -> one mem_read cycle, then one mem_write cycle with data 0x12AB5678; resp after 3 cycles; a following LW returns 0x12AB5678.
- SW 0x10001004 with data 0x33334444 -> single mem_write cycle, data 0x33334444, address 0x10001004, no mem_read.
- LH 0x10001011, SW 0x10001002, and opcode 000000 -> each gives resp_fault=1 one cycle after accept, mem_read and mem_write never high, resp_rdata 0.
- With LSU_RANGE_CHECK_EN defined, LW 0x10001040 -> fault with no strobes. rst pulsed during the WR state of an SB -> mem_write drops immediately, no resp_valid, req_ready=1.

Source files
------------

// File: rtl/mips_load_store_unit.sv
// mips_load_store_unit: load/store initiator to word-addressed data memory; LSU_RANGE_CHECK_EN enables window fault check
module mips_load_store_unit #(
  parameter logic [31:0] BASE_ADDR = 32'h10001000,
  parameter int DEPTH_WORDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_opcode,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_read_data
);
  localparam logic [2:0] IDLE = 3'd0, RD = 3'd1, RMW_RD = 3'd2, WR = 3'd3, RESP = 3'd4;
  localparam logic [5:0] OP_LB = 6'b100000, OP_LH = 6'b100001, OP_LW = 6'b100011, OP_LBU = 6'b100100,
                         OP_LHU = 6'b100101, OP_SB = 6'b101000, OP_SH = 6'b101001, OP_SW = 6'b101011;
  localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * DEPTH_WORDS) - 32'd1;
  localparam logic RANGE_EN =
`ifdef LSU_RANGE_CHECK_EN
    1'b1;
`else
    1'b0;
`endif
  logic [2:0]  state, next;
  logic [5:0]  op;
  logic [1:0]  off;
  logic [15:0] wdata;
  logic        accept, legal, is_load, misaligned, out_of_range, fault;
  logic [4:0]  bshift;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] load_val, merged;
  // request decode, next state, load extraction and sub-word merge
  always_comb begin
    accept = req_valid & req_ready;
    is_load = req_opcode == OP_LB || req_opcode == OP_LH || req_opcode == OP_LW ||
              req_opcode == OP_LBU || req_opcode == OP_LHU;
    legal = is_load || req_opcode == OP_SB || req_opcode == OP_SH || req_opcode == OP_SW;
    misaligned = ((req_opcode == OP_LH || req_opcode == OP_LHU || req_opcode == OP_SH) && req_addr[0]) ||
                 ((req_opcode == OP_LW || req_opcode == OP_SW) && req_addr[1:0] != 2'b00);
    out_of_range = RANGE_EN && (req_addr < BASE_ADDR || req_addr > LAST_ADDR);
    fault = !legal || misaligned || out_of_range;
    next = state == IDLE ? (!accept ? IDLE : fault ? RESP : is_load ? RD : req_opcode == OP_SW ? WR : RMW_RD) :
           state == RD ? RESP :
           state == RMW_RD ? WR :
           state == WR ? RESP : IDLE;
    bshift = {~off, 3'b000};
    rbyte = off[1] ? (off[0] ? mem_read_data[7:0] : mem_read_data[15:8])
                   : (off[0] ? mem_read_data[23:16] : mem_read_data[31:24]);
    rhalf = off[1] ? mem_read_data[15:0] : mem_read_data[31:16];
    load_val = op == OP_LB  ? {{24{rbyte[7]}}, rbyte} :
               op == OP_LBU ? {24'b0, rbyte} :
               op == OP_LH  ? {{16{rhalf[15]}}, rhalf} :
               op == OP_LHU ? {16'b0, rhalf} : mem_read_data;
    merged = op == OP_SB ? (mem_read_data & ~(32'h000000FF << bshift)) | ({24'b0, wdata[7:0]} << bshift) :
             off[1] ? {mem_read_data[31:16], wdata} : {wdata, mem_read_data[15:0]};
  end
  // state, captured request and registered memory/response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      op <= '0;
      off <= '0;
      wdata <= '0;
      req_ready <= 1'b1;
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      resp_rdata <= '0;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
      mem_address <= '0;
      mem_write_data <= '0;
    end else begin
      state <= next;
      req_ready <= next == IDLE;
      mem_read <= next == RD || next == RMW_RD;
      mem_write <= next == WR;
      resp_valid <= next == RESP;
      resp_fault <= accept && fault;
      resp_rdata <= state == RD ? load_val : 32'd0;
      if (accept) begin
        op <= req_opcode;
        off <= req_addr[1:0];
        wdata <= req_wdata[15:0];
        mem_address <= {req_addr[31:2], 2'b00};
        mem_write_data <= req_wdata;
      end
      if (state == RMW_RD) mem_write_data <= merged;
    end
  end
endmodule

// File: tb/tb_mips_load_store_unit.sv
// tb_mips_load_store_unit: directed and randomized load/store checks against a word-array reference model
module tb_mips_load_store_unit;
  localparam logic [31:0] BASE = 32'h10001000;
  localparam logic [5:0] LB = 6'b100000, LH = 6'b100001, LW = 6'b100011, LBU = 6'b100100,
                         LHU = 6'b100101, SB = 6'b101000, SH = 6'b101001, SW = 6'b101011;
  logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0;
  logic [5:0] req_opcode = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic req_ready, resp_valid, resp_fault, mem_read, mem_write;
  logic [31:0] resp_rdata, mem_address, mem_write_data, mem_read_data;
  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];
  int vectors = 0, miscompares = 0;

  mips_load_store_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_fault(resp_fault), .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  assign mem_read_data = mem_read ? mem[mem_address[5:2]] : 32'hDEADBEEF;
  always @(posedge clk) if (mem_write) mem[mem_address[5:2]] <= mem_write_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return op == LB || op == LH || op == LW || op == LBU || op == LHU || op == SB || op == SH || op == SW;
  endfunction

  function automatic bit model_fault(input logic [5:0] op, input logic [31:0] a);
    bit f;
    f = !is_legal(op) || ((op == LH || op == LHU || op == SH) && a % 2 != 0) || ((op == LW || op == SW) && a % 4 != 0);
`ifdef LSU_RANGE_CHECK_EN
    f = f || a < BASE || a > BASE + 63;
`endif
    return f;
  endfunction

  task automatic req(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output logic flt);
    int nr, nw, nv, lat, exp_lat, idx, sh;
    logic [31:0] ra, wa, wdat, w, v, e;
    bit f, ld, st, sub;
    nr = 0; nw = 0; nv = 0; lat = 0; ra = '0; wa = '0; wdat = '0; rd = '0; flt = 1'b0;
    @(negedge clk);
    chk("ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_opcode = op; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0; req_opcode = 6'($urandom); req_addr = $urandom; req_wdata = $urandom;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (mem_read) begin nr++; ra = mem_address; end
      if (mem_write) begin nw++; wa = mem_address; wdat = mem_write_data; end
      if (resp_valid) begin nv++; lat = c; rd = resp_rdata; flt = resp_fault; end
    end
    f = model_fault(op, a);
    ld = !f && (op == LB || op == LH || op == LW || op == LBU || op == LHU);
    st = !f && (op == SB || op == SH || op == SW);
    sub = st && op != SW;
    exp_lat = f ? 1 : sub ? 3 : 2;
    idx = (a - BASE) / 4;
    w = ref_mem[idx % 16];
    e = '0;
    if (ld) begin
      if (op == LB || op == LBU) begin
        v = (w >> (8 * (3 - a % 4))) % 256;
        e = (op == LB && v >= 128) ? v + 32'hFFFFFF00 : v;
      end else if (op == LH || op == LHU) begin
        v = (w >> (8 * (2 - a % 4))) % 65536;
        e = (op == LH && v >= 32768) ? v + 32'hFFFF0000 : v;
      end else e = w;
    end
    chk($sformatf("latency op=%b a=%h", op, a), lat, exp_lat);
    chk("resp_once", nv, 1);
    chk($sformatf("fault op=%b a=%h", op, a), {31'b0, flt}, {31'b0, f});
    chk($sformatf("rdata op=%b a=%h", op, a), rd, e);
    chk("read_count", nr, (ld || sub) ? 1 : 0);
    chk("write_count", nw, st ? 1 : 0);
    if (nr > 0) chk("read_addr", ra, a & 32'hFFFFFFFC);
    if (st) begin
      if (op == SW) v = wd;
      else if (op == SB) begin
        sh = 8 * (3 - a % 4);
        v = w - (((w >> sh) % 256) << sh) + ((wd % 256) << sh);
      end else begin
        sh = 8 * (2 - a % 4);
        v = w - (((w >> sh) % 65536) << sh) + ((wd % 65536) << sh);
      end
      chk("write_addr", wa, a & 32'hFFFFFFFC);
      chk($sformatf("write_data op=%b a=%h", op, a), wdat, v);
      ref_mem[idx % 16] = v;
    end
    chk("ready_after", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] rd, a;
    logic flt;
    logic [5:0] op;
    int nv;
    logic [5:0] ops [9];
    ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW, 6'b000000};
    for (int i = 0; i < 16; i++) begin mem[i] = $urandom; ref_mem[i] = mem[i]; end
    mem[4] = 32'h12345678; ref_mem[4] = 32'h12345678;
    #12;
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_fault", {31'b0, resp_fault}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_strobes", {30'b0, mem_read, mem_write}, 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_mem_wdata", mem_write_data, 32'd0);
    @(negedge clk); rst = 1'b0;

    req(LW, 32'h10001010, 0, rd, flt);          chk("plan_lw", rd, 32'h12345678);
    req(LB, 32'h10001010, 0, rd, flt);          chk("plan_lb0", rd, 32'h00000012);
    req(LB, 32'h10001013, 0, rd, flt);          chk("plan_lb3", rd, 32'h00000078);
    req(LH, 32'h10001012, 0, rd, flt);          chk("plan_lh2", rd, 32'h00005678);
    req(SW, 32'h10001010, 32'h80FF0000, rd, flt);
    req(LB, 32'h10001010, 0, rd, flt);          chk("plan_lb_neg", rd, 32'hFFFFFF80);
    req(LBU, 32'h10001010, 0, rd, flt);         chk("plan_lbu", rd, 32'h00000080);
    req(LHU, 32'h10001010, 0, rd, flt);         chk("plan_lhu", rd, 32'h000080FF);
    req(SW, 32'h10001010, 32'h12345678, rd, flt);
    req(SB, 32'h10001011, 32'h000000AB, rd, flt);
    req(LW, 32'h10001010, 0, rd, flt);          chk("plan_sb_merge", rd, 32'h12AB5678);
    req(SW, 32'h10001004, 32'h33334444, rd, flt);
    chk("plan_sw_mem", mem[1], 32'h33334444);
    req(LH, 32'h10001011, 0, rd, flt);          chk("plan_lh_mis", {31'b0, flt}, 32'd1);
    req(SW, 32'h10001002, 32'h5555AAAA, rd, flt); chk("plan_sw_mis", {31'b0, flt}, 32'd1);
    req(6'b000000, 32'h10001010, 0, rd, flt);   chk("plan_illegal", {31'b0, flt}, 32'd1);
`ifdef LSU_RANGE_CHECK_EN
    req(LW, 32'h10001040, 0, rd, flt);          chk("plan_range", {31'b0, flt}, 32'd1);
`endif

    @(negedge clk);
    req_valid = 1'b1; req_opcode = SB; req_addr = 32'h10001009; req_wdata = 32'h000000CD;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_in_wr", {31'b0, mem_write}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_write_drop", {31'b0, mem_write}, 32'd0);
    chk("rst_mid_resp", {31'b0, resp_valid}, 32'd0);
    chk("rst_mid_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk); rst = 1'b0;
    nv = 0;
    for (int c = 0; c < 4; c++) begin @(negedge clk); if (resp_valid) nv++; end
    chk("rst_mid_no_resp", nv, 0);
    chk("rst_mid_mem_kept", mem[2], ref_mem[2]);
    req(LW, 32'h10001008, 0, rd, flt);

    for (int i = 0; i < 80; i++) begin
      op = ops[$urandom_range(0, 8)];
      if (op == 6'b000000) op = 6'($urandom);
      a = BASE + $urandom_range(0, 63);
      if ($urandom_range(0, 3) != 0)
        a = (op == LH || op == LHU || op == SH) ? a & 32'hFFFFFFFE :
            (op == LW || op == SW) ? a & 32'hFFFFFFFC : a;
      req(op, a, $urandom, rd, flt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
